or_gate: RTL and testbench



---
 rtl/logic_gates_pkg.sv | 14 +
 rtl/or_gate_if.sv | 33 +++
 rtl/or_gate_reg.sv | 29 ++
 rtl/or_gate.sv | 65 ++++++
 tb/tb_or_gate.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/logic_gates_pkg.sv
// Shared constants for the logic-gate library.
//   GATE_WIDTH_DEFAULT : default operand width of every gate
//   GATE_WIDTH_MAX     : widest operand width a gate may be built with
package logic_gates_pkg;

  localparam int GATE_WIDTH_DEFAULT = 1;
  localparam int GATE_WIDTH_MAX     = 64;

  // Legal widths are 1..GATE_WIDTH_MAX.
  function automatic bit gate_width_ok(input int w);
    return (w >= 1) && (w <= GATE_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/or_gate_if.sv
// Bus bundle of the or_gate block.
//   a, b     : operands (WIDTH)
//   acc_clr  : synchronous clear of the sticky accumulator
//   out      : combinational a | b
//   out_q    : out registered one cycle
//   any_q    : registered reduction OR of out
//   acc      : sticky OR of every out since last clear/reset
// master drives operands and clear; slave is the gate itself.
interface or_gate_if
  import logic_gates_pkg::*;
#(
  parameter int WIDTH = GATE_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             any_q;
  logic [WIDTH-1:0] acc;

  modport master (
    output a, b, acc_clr,
    input  out, out_q, any_q, acc
  );

  modport slave (
    input  a, b, acc_clr,
    output out, out_q, any_q, acc
  );

endinterface

// File: rtl/or_gate_reg.sv
// WIDTH-wide register with asynchronous active-high reset to zero.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   d_i : next value
//   q_o : registered value
module or_gate_reg
  import logic_gates_pkg::*;
#(
  parameter int WIDTH = GATE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/or_gate.sv
// Parameterised bitwise two-input OR with a combinational result, a
// one-cycle registered copy, a registered "any bit set" flag and a sticky
// OR accumulator.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset; clears out_q, any_q, acc
//   bus  : or_gate_if slave (a, b, acc_clr in; out, out_q, any_q, acc out)
// out never depends on clk/rst, so the block also serves as a plain gate.
module or_gate
  import logic_gates_pkg::*;
#(
  parameter int WIDTH = GATE_WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  or_gate_if.slave   bus
);

  if (!gate_width_ok(WIDTH)) begin : g_width_check
    $fatal(1, "or_gate: WIDTH=%0d outside 1..%0d", WIDTH, GATE_WIDTH_MAX);
  end

  logic [WIDTH-1:0] out_d;
  logic             any_d;
  logic             any_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_q;

  // Combinational result; X on one operand is masked only by a 1 on the other.
  assign out_d   = bus.a | bus.b;
  assign bus.out = out_d;

  assign any_d = |out_d;

  // Clear wins over accumulation in the same cycle.
  always_comb begin
    acc_d = acc_q | out_d;
    if (bus.acc_clr) begin
      acc_d = '0;
    end
  end

  // ---- registered stage ----
  or_gate_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk (clk),
    .rst (rst),
    .d_i (out_d),
    .q_o (bus.out_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_q <= 1'b0;
      acc_q <= '0;
    end else begin
      any_q <= any_d;
      acc_q <= acc_d;
    end
  end

  assign bus.any_q = any_q;
  assign bus.acc   = acc_q;

endmodule

// File: tb/tb_or_gate.sv
// Self-checking bench for or_gate: a WIDTH=1 instance for the truth table
// and a WIDTH=16 instance for directed and randomized clocked checks
// against a behavioural model.
module tb_or_gate;

  localparam int W = 16;

  logic clk;
  logic rst;
  bit   chk_en;

  int checks;
  int failures;

  or_gate_if #(.WIDTH(W)) bus16 ();
  or_gate_if #(.WIDTH(1)) bus1 ();

  or_gate #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  or_gate #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: value of a|b seen at the last edge, and the OR of
  // every a|b since the last clear or reset.
  logic [W-1:0] m_prev;
  logic [W-1:0] m_acc;

  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_prev = '0;
      m_acc  = '0;
    end else begin
      m_prev = bus16.a | bus16.b;
      if (bus16.acc_clr) m_acc = '0;
      else               m_acc = m_acc | m_prev;
    end
  end

  // Compare process, away from the rising edge.
  always @(negedge clk) begin
    check("out_comb", 64'(bus16.out), 64'(bus16.a | bus16.b));
    if (chk_en) begin
      check("out_q", 64'(bus16.out_q), 64'(m_prev));
      check("any_q", 64'(bus16.any_q), 64'(m_prev != '0));
      check("acc",   64'(bus16.acc),   64'(m_acc));
    end
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] tt;
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst      = 1'b1;
    bus16.a = '0; bus16.b = '0; bus16.acc_clr = 1'b0;
    bus1.a  = '0; bus1.b  = '0; bus1.acc_clr  = 1'b0;

    // Truth table at WIDTH=1 (combinational, valid during reset).
    for (int i = 0; i < 4; i++) begin
      tt = 2'(i);
      bus1.a = tt[1];
      bus1.b = tt[0];
      #1;
      check("truth_table", 64'(bus1.out), 64'(i != 0));
    end

    next_edge();
    next_edge();
    check("rst_out_q", 64'(bus16.out_q), 64'h0);
    check("rst_any_q", 64'(bus16.any_q), 64'h0);
    check("rst_acc",   64'(bus16.acc),   64'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // 8-bit pattern A0 | 05.
    bus16.a = 16'h00A0; bus16.b = 16'h0005;
    #1;
    check("out_A5_imm", 64'(bus16.out), 64'h00A5);
    next_edge();
    check("out_q_A5", 64'(bus16.out_q), 64'h00A5);
    check("any_q_1",  64'(bus16.any_q), 64'h1);
    bus16.a = '0; bus16.b = '0;
    next_edge();
    check("any_q_0", 64'(bus16.any_q), 64'h0);

    // Accumulator sequence.
    bus16.acc_clr = 1'b1;
    next_edge();
    check("acc_clr0", 64'(bus16.acc), 64'h0);
    bus16.acc_clr = 1'b0;
    bus16.a = 16'h1;
    next_edge();
    check("acc_1", 64'(bus16.acc), 64'h1);
    bus16.a = 16'h4;
    next_edge();
    check("acc_5", 64'(bus16.acc), 64'h5);
    bus16.a = 16'h0;
    next_edge();
    check("acc_5_hold", 64'(bus16.acc), 64'h5);
    bus16.a = 16'h8; bus16.acc_clr = 1'b1;
    next_edge();
    check("acc_clr_prio", 64'(bus16.acc), 64'h0);
    bus16.acc_clr = 1'b0;
    next_edge();
    check("acc_8", 64'(bus16.acc), 64'h8);

    // Asynchronous reset between edges.
    bus16.a = 16'h00FF; bus16.b = 16'h0000;
    next_edge();
    check("pre_rst_out_q", 64'(bus16.out_q), 64'h00FF);
    check("pre_rst_acc",   64'(bus16.acc),   64'h00FF);
    #1;
    rst = 1'b1;
    #1;
    check("async_out_q", 64'(bus16.out_q), 64'h0);
    check("async_any_q", 64'(bus16.any_q), 64'h0);
    check("async_acc",   64'(bus16.acc),   64'h0);
    check("async_out",   64'(bus16.out),   64'h00FF);
    next_edge();
    rst = 1'b0;

    // Randomized operands with occasional clears.
    for (int n = 0; n < 1000; n++) begin
      bus16.a       = W'($urandom);
      bus16.b       = W'($urandom);
      bus16.acc_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) bus16.b = '0;
      if ($urandom_range(0, 7) == 0) bus16.a = '0;
      next_edge();
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
